// File: rtl/mac_out_conv.sv
// Re-encodes fp/int accumulator results into 16-bit value words (ReLU, requant, saturate, int8 pair packing).
// Two-stage valid/ready pipeline with full backpressure; `MAC_OUT_ROUND_EN selects half-up rounding in int mode.
module mac_out_conv #(
  parameter int EXP_ADJ = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mode,
  input  logic [4:0]  shift,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [17:0] acc_fp,
  input  logic [23:0] acc_int,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic [15:0] sat_cnt
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_HALF  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic signed [6:0] ADJ = 7'(EXP_ADJ);

  // ---------------- fp conversion ----------------
  logic [4:0]         fp_e;
  logic [12:0]        fp_m;
  logic [3:0]         lead_p;
  logic [3:0]         norm_sh;
  logic [11:0]        fp_norm;
  logic signed [6:0]  fp_exp;
  logic [15:0]        fp_res;
  logic               fp_sat;

  assign fp_e    = acc_fp[17:13];
  assign fp_m    = acc_fp[12:0];
  assign norm_sh = 4'd11 - lead_p;
  assign fp_norm = fp_m[11:0] << norm_sh;
  assign fp_exp  = $signed({2'b00, fp_e}) - $signed({3'b000, norm_sh}) + ADJ;

  always_comb begin
    lead_p = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (fp_m[i]) lead_p = 4'(i);
    end
  end

  always_comb begin
    fp_res = 16'h0000;
    fp_sat = 1'b0;
    if (fp_m[12] || (fp_m[11:0] == 12'd0)) begin
      fp_res = 16'h0000;
    end else if (fp_exp < 0) begin
      fp_res = 16'h0000;
    end else if (fp_exp > 7'sd31) begin
      fp_res = 16'hFFFF;
      fp_sat = 1'b1;
    end else begin
      fp_res = {fp_exp[4:0], fp_norm[10:0]};
    end
  end

  // ---------------- int conversion ----------------
  logic signed [24:0] int_ext;
  logic signed [24:0] int_rnd;
  logic signed [24:0] int_r;
  logic [7:0]         int_res;
  logic               int_sat;

  assign int_ext = $signed({acc_int[23], acc_int});

`ifdef MAC_OUT_ROUND_EN
  assign int_rnd = (shift != 5'd0) ? (25'sd1 <<< (shift - 5'd1)) : 25'sd0;
`else
  assign int_rnd = 25'sd0;
`endif

  assign int_r = (int_ext + int_rnd) >>> shift;

  always_comb begin
    int_res = int_r[7:0];
    int_sat = 1'b0;
    if (int_r[24]) begin
      int_res = 8'd0;
    end else if (|int_r[23:8]) begin
      int_res = 8'd255;
      int_sat = 1'b1;
    end
  end

  logic        cv_fp;
  logic [15:0] cv_dat;
  logic        cv_sat;

  assign cv_fp  = mode[0];
  assign cv_dat = cv_fp ? fp_res : {8'h00, int_res};
  assign cv_sat = cv_fp ? fp_sat : int_sat;

  // ---------------- S1 / S2 state ----------------
  logic        s1_vld_q, s1_fp_q, s1_last_q;
  logic [15:0] s1_dat_q;
  logic [1:0]  st_q, st_d;
  logic [15:0] word_q, word_d;
  logic        last_q, last_d;
  logic [7:0]  low_q, low_d;
  logic [15:0] sat_q, sat_d;
  logic        s1_take;
  logic        s2_open;
  logic        accept;

  // A FULL word being drained this cycle frees S2 exactly like EMPTY.
  assign s2_open = (st_q == S_EMPTY) || ((st_q == S_FULL) && out_ready);

  always_comb begin
    st_d    = st_q;
    word_d  = word_q;
    last_d  = last_q;
    low_d   = low_q;
    s1_take = 1'b0;
    if ((st_q == S_FULL) && out_ready) st_d = S_EMPTY;
    if (s1_vld_q) begin
      if (s2_open) begin
        s1_take = 1'b1;
        if (s1_fp_q) begin
          st_d   = S_FULL;
          word_d = s1_dat_q;
          last_d = s1_last_q;
        end else if (s1_last_q) begin
          st_d   = S_FULL;
          word_d = {8'h00, s1_dat_q[7:0]};
          last_d = 1'b1;
        end else begin
          st_d  = S_HALF;
          low_d = s1_dat_q[7:0];
        end
      end else if (st_q == S_HALF) begin
        st_d = S_FULL;
        if (s1_fp_q) begin
          // Flush the lone byte first; the fp item waits in S1.
          word_d = {8'h00, low_q};
          last_d = 1'b0;
        end else begin
          s1_take = 1'b1;
          word_d  = {s1_dat_q[7:0], low_q};
          last_d  = s1_last_q;
        end
      end
    end
  end

  assign in_ready = !s1_vld_q || s1_take;
  assign accept   = in_valid && in_ready;
  assign sat_d    = (accept && cv_sat && (sat_q != 16'hFFFF)) ? sat_q + 16'd1 : sat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_fp_q   <= 1'b0;
      s1_last_q <= 1'b0;
      s1_dat_q  <= 16'h0000;
      st_q      <= S_EMPTY;
      word_q    <= 16'h0000;
      last_q    <= 1'b0;
      low_q     <= 8'h00;
      sat_q     <= 16'h0000;
    end else begin
      if (accept) begin
        s1_vld_q  <= 1'b1;
        s1_fp_q   <= cv_fp;
        s1_last_q <= in_last;
        s1_dat_q  <= cv_dat;
      end else if (s1_take) begin
        s1_vld_q  <= 1'b0;
      end
      st_q   <= st_d;
      word_q <= word_d;
      last_q <= last_d;
      low_q  <= low_d;
      sat_q  <= sat_d;
    end
  end

  assign out_valid = (st_q == S_FULL);
  assign out_data  = word_q;
  assign out_last  = last_q;
  assign sat_cnt   = sat_q;

endmodule
